// File: rtl/alu_pkg.sv
// Shared ALU function codes and mul_seq state encoding.
// Imported by alu and mul_seq.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL1 = 3'b101,
    ALU_SHR1 = 3'b110,
    ALU_PASS = 3'b111
  } alu_func_e;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'b00,
    MS_ADD   = 2'b01,
    MS_SHIFT = 2'b10,
    MS_DONE  = 2'b11
  } mul_state_e;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU.
// Ports: func (op code), a, b (operands), out (result), c_out (carry/borrow).
module alu
  import alu_pkg::*;
(
  input  alu_func_e   func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        c_out
);

  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    out   = '0;
    c_out = 1'b0;
    unique case (func)
      ALU_ADD: begin
        out   = sum[31:0];
        c_out = sum[32];
      end
      ALU_SUB: begin
        out   = diff[31:0];
        c_out = diff[32];
      end
      ALU_AND:  out = a & b;
      ALU_OR:   out = a | b;
      ALU_XOR:  out = a ^ b;
      ALU_SHL1: out = {a[30:0], 1'b0};
      ALU_SHR1: out = {1'b0, a[31:1]};
      ALU_PASS: out = a;
      default: begin
        out   = '0;
        c_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 unsigned shift-add multiplier on one shared ALU.
// Ports: clk, rst (async high), start, a, b in; busy, done, product out.
module mul_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mul_state_e  state_q;
  mul_state_e  state_d;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        carry;
  logic [4:0]  count;

  alu_func_e   alu_func;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_c;

  logic        accept;
  logic [31:0] hi_shr;
  logic [31:0] lo_shr;

  alu u_alu (
    .func  (alu_func),
    .a     (alu_a),
    .b     (alu_b),
    .out   (alu_out),
    .c_out (alu_c)
  );

  assign accept = start &&
    (state_q == MS_IDLE || state_q == MS_DONE);

  // carry is the 33rd accumulator bit; it enters at bit 31
  assign hi_shr = {carry, alu_out[30:0]};
  assign lo_shr = {hi[0], lo[31:1]};

  assign busy = (state_q == MS_ADD) ||
                (state_q == MS_SHIFT);
  assign done = (state_q == MS_DONE);

  always_comb begin
    state_d  = state_q;
    alu_func = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    unique case (state_q)
      MS_IDLE: begin
        if (start) state_d = MS_ADD;
      end
      MS_ADD: begin
        alu_func = ALU_ADD;
        alu_a    = hi;
        alu_b    = mcand;
        state_d  = MS_SHIFT;
      end
      MS_SHIFT: begin
        alu_func = ALU_SHR1;
        alu_a    = hi;
        if (count == 5'd31) state_d = MS_DONE;
        else                state_d = MS_ADD;
      end
      MS_DONE: begin
        if (start) state_d = MS_ADD;
        else       state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MS_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      carry   <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      unique case (state_q)
        MS_IDLE, MS_DONE: begin
          if (accept) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            carry <= 1'b0;
            count <= '0;
          end
        end
        MS_ADD: begin
          if (lo[0]) begin
            hi    <= alu_out;
            carry <= alu_c;
          end else begin
            carry <= 1'b0;
          end
        end
        MS_SHIFT: begin
          hi    <= hi_shr;
          lo    <= lo_shr;
          count <= count + 5'd1;
          if (count == 5'd31)
            product <= {hi_shr, lo_shr};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq.
// Hand-computed products, latency, busy width, reset behaviour.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks;
  int failures;

  mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Drive start for one edge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] av,
                       input logic [31:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Caller is #1 into cycle k+i0; runs to the done cycle.
  task automatic finish_op(input logic [63:0] exp,
                           input string tag,
                           input int i0);
    int i;
    int busy_n;
    i = i0;
    busy_n = 0;
    while (done !== 1'b1 && i < 200) begin
      if (busy === 1'b1) busy_n++;
      @(posedge clk);
      #1;
      i++;
    end
    check({tag, "_lat"}, 64'(i), 64'd65);
    check({tag, "_busy"}, 64'(busy_n), 64'(65 - i0));
    check({tag, "_prod"}, product, exp);
  endtask

  initial begin
    int seen;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(32'd3, 32'd5);
    finish_op(64'hF, "mul3x5", 1);
    @(posedge clk);
    #1;
    check("post_done", 64'(done), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
    check("post_hold", product, 64'hF);

    issue(32'd7, 32'd6);
    repeat (8) @(posedge clk);
    @(negedge clk);
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mid_hold", product, 64'hF);
    finish_op(64'd42, "ignore", 10);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op(64'hFFFF_FFFE_0000_0001, "max", 1);

    issue(32'h1234_5678, 32'd0);
    finish_op(64'd0, "b_zero", 1);

    issue(32'd0, 32'hDEAD_BEEF);
    finish_op(64'd0, "a_zero", 1);

    issue(32'd5, 32'd5);
    finish_op(64'd25, "mul5x5", 1);
    issue(32'd2, 32'h8000_0000);
    finish_op(64'h1_0000_0000, "restart", 1);

    issue(32'd100, 32'd3);
    repeat (29) @(posedge clk);
    #3;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_prod", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);

    issue(32'd11, 32'd13);
    finish_op(64'd143, "mul11x13", 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
